hazard_ctrl_unit: RTL

//  Pipeline hazard controller for the 5-stage RISC-V core; successor to the forwarding-only unit.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_sel.sv | 29 ++
 rtl/hazard_ctrl_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multi-cycle MUL/DIV tracking state
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage operand forwarding select for one source operand; MEM beats WB.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode of pipeline destination/source fields.
// Ports: i_reg_write_m/i_rd_m (MEM writer), i_reg_write_w/i_rd_w (WB writer),
//        i_rs_e (EX source), o_fwd (FWD_RF / FWD_WB / FWD_MEM).
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_reg_write_m,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_reg_write_w,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic [REG_AW-1:0] i_rs_e,
  output logic [1:0]        o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    // x0 is never a real producer, so a write to it must not forward.
    if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: EX forwarding, load-use and MUL/DIV scoreboard stalls, branch flushes, perf counters.
// Latency: stall/flush/forward outputs are combinational (zero cycles); md_busy, scoreboard and counters are registered.
// Backpressure: produces it -- StallF/StallD hold the front end, FlushE injects a bubble; nothing pushes back on this block.
// Ports: clk, rst (async active-low); pipeline fields Rs*/RD* per stage with RegWrite*/ResultSrcE0/MdOpD qualifiers;
//        MdStartE/MdDoneW pulses from the MD unit; PCSrcE taken branch; cnt_clr clears counters.
//        Outputs ForwardAE/BE, StallF, StallD, FlushD, FlushE, md_busy, stall_cnt, flush_cnt.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              MdOpD,
  input  logic              MdStartE,
  input  logic              MdDoneW,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] RD_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int NREG = 2 ** REG_AW;

  md_state_t         r_state, w_state_nxt;
  logic [NREG-1:0]   r_pending, w_pending_nxt;
  logic [REG_AW-1:0] r_md_rd, w_md_rd_nxt;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic [1:0]        w_fwd_a, w_fwd_b;
  logic              w_lw_stall, w_sb_stall, w_stall;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_reg_write_m (RegWriteM),
    .i_rd_m        (RD_M),
    .i_reg_write_w (RegWriteW),
    .i_rd_w        (RD_W),
    .i_rs_e        (Rs1_E),
    .o_fwd         (w_fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_reg_write_m (RegWriteM),
    .i_rd_m        (RD_M),
    .i_reg_write_w (RegWriteW),
    .i_rd_w        (RD_W),
    .i_rs_e        (Rs2_E),
    .o_fwd         (w_fwd_b)
  );

  // Stall detection. pending[0] is never set, so x0 sources never stall.
  always_comb begin
    w_lw_stall = ResultSrcE0 && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    // RD_D is checked too so a younger write cannot land before the MD result (WAW).
    w_sb_stall = r_pending[Rs1_D] | r_pending[Rs2_D] | r_pending[RD_D]
               | (MdOpD & (r_state == MD_BUSY));
    // A taken branch kills the D-stage instruction, so stalling it is pointless.
    w_stall    = (w_lw_stall | w_sb_stall) & ~PCSrcE;
  end

  // Combinational outputs are held quiet while reset is asserted.
  assign ForwardAE = rst ? w_fwd_a : FWD_RF;
  assign ForwardBE = rst ? w_fwd_b : FWD_RF;
  assign StallF    = rst & w_stall;
  assign StallD    = rst & w_stall;
  assign FlushD    = rst & PCSrcE;
  assign FlushE    = rst & (w_stall | PCSrcE);
  assign md_busy   = (r_state == MD_BUSY);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // MD tracking FSM and scoreboard next-state.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_md_rd_nxt   = r_md_rd;
    case (r_state)
      MD_IDLE: begin
        // A stray MdDoneW while idle is ignored.
        if (MdStartE) begin
          w_state_nxt = MD_BUSY;
          w_md_rd_nxt = RD_E;
          if (RD_E != '0) w_pending_nxt[RD_E] = 1'b1;
        end
      end
      MD_BUSY: begin
        // MdStartE without MdDoneW here is illegal and deliberately ignored.
        if (MdDoneW) begin
          w_pending_nxt[r_md_rd] = 1'b0;
          if (MdStartE) begin
            // Back-to-back op: set is applied after clear so it wins on the same reg.
            w_md_rd_nxt = RD_E;
            if (RD_E != '0) w_pending_nxt[RD_E] = 1'b1;
          end else begin
            w_state_nxt = MD_IDLE;
          end
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= MD_IDLE;
      r_pending <= '0;
      r_md_rd   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_md_rd   <= w_md_rd_nxt;
    end
  end

  // Saturating perf counters; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FlushD && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule
